// File: rtl/s_mem_check.sv
// Read-back checker for the 256x8 S memory: sweeps all addresses and checks
// either the identity fill (S[i]==i) or that the contents form a permutation.
module s_mem_check #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  output logic       rdy,
  output logic [7:0] addr,
  output logic       rden,
  input  logic [7:0] rddata,
  output logic       pass,
  output logic [7:0] err_addr,
  output logic [7:0] err_data
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic             rden_q, rden_d;
  logic             mode_q, mode_d;
  logic [255:0]     seen_q, seen_d;
  logic             err_q, err_d;
  logic             pass_q, pass_d;
  logic [7:0]       err_addr_q, err_addr_d;
  logic [7:0]       err_data_q, err_data_d;
  logic [MEM_LATENCY-1:0] vld_q, vld_d;
  logic [7:0]       idx_q [MEM_LATENCY];
  logic [7:0]       idx_d [MEM_LATENCY];

  logic       start;
  logic       cmp_vld;
  logic [7:0] cmp_idx;
  logic       cmp_err;

  assign rdy      = (state_q == StIdle) || (state_q == StDone);
  assign start    = en && rdy;
  assign addr     = addr_q;
  assign rden     = rden_q;
  assign pass     = pass_q;
  assign err_addr = err_addr_q;
  assign err_data = err_data_q;

  // Oldest stage of the in-flight tracker lines up with rddata.
  assign cmp_vld = vld_q[MEM_LATENCY-1];
  assign cmp_idx = idx_q[MEM_LATENCY-1];
  assign cmp_err = cmp_vld && (mode_q ? seen_q[rddata] : (rddata != cmp_idx));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rden_d     = rden_q;
    mode_d     = mode_q;
    seen_d     = seen_q;
    err_d      = err_q;
    pass_d     = pass_q;
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;

    vld_d[0] = rden_q;
    idx_d[0] = addr_q;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end

    unique case (state_q)
      StRead: begin
        addr_d = addr_q + 8'd1;
        if (addr_q == 8'd255) begin
          rden_d  = 1'b0;
          state_d = StDrain;
        end
      end
      StDone:  state_d = StIdle;
      default: ;
    endcase

    if (cmp_vld) begin
      if (mode_q) seen_d[rddata] = 1'b1;
      if (cmp_err && !err_q) begin
        err_d      = 1'b1;
        err_addr_d = cmp_idx;
        err_data_d = rddata;
      end
      if (cmp_idx == 8'd255) begin
        state_d = StDone;
        pass_d  = !(err_q || cmp_err);
      end
    end

    if (start) begin
      state_d    = StRead;
      addr_d     = 8'd0;
      rden_d     = 1'b1;
      mode_d     = mode;
      seen_d     = '0;
      err_d      = 1'b0;
      pass_d     = 1'b0;
      err_addr_d = 8'd0;
      err_data_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= 8'd0;
      rden_q     <= 1'b0;
      mode_q     <= 1'b0;
      seen_q     <= '0;
      err_q      <= 1'b0;
      pass_q     <= 1'b0;
      err_addr_q <= 8'd0;
      err_data_q <= 8'd0;
      vld_q      <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) idx_q[i] <= 8'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rden_q     <= rden_d;
      mode_q     <= mode_d;
      seen_q     <= seen_d;
      err_q      <= err_d;
      pass_q     <= pass_d;
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
      vld_q      <= vld_d;
      for (int i = 0; i < MEM_LATENCY; i++) idx_q[i] <= idx_d[i];
    end
  end

endmodule

// File: tb/tb_s_mem_check.sv
// Bench for s_mem_check: a latency-1 and a latency-3 instance, each fed by
// a modelled S memory; results checked against a sweep-level reference.
module tb_s_mem_check;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en1, mode1, rdy1, rden1, pass1;
  logic [7:0] addr1, rd1, ea1, ed1;
  logic       en3, mode3, rdy3, rden3, pass3;
  logic [7:0] addr3, rd3, ea3, ed3;
  logic [7:0] p3a, p3b;
  logic [7:0] mem [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  s_mem_check #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .rdy(rdy1), .addr(addr1),
    .rden(rden1), .rddata(rd1), .pass(pass1), .err_addr(ea1), .err_data(ed1)
  );

  s_mem_check #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .rdy(rdy3), .addr(addr3),
    .rden(rden3), .rddata(rd3), .pass(pass3), .err_addr(ea3), .err_data(ed3)
  );

  // Memory with one or three register stages between address and data.
  always @(posedge clk) begin
    rd1 <= mem[addr1];
    p3a <= addr3;
    p3b <= p3a;
    rd3 <= mem[p3b];
  end

  // Reference: scan the words in address order, first violation wins.
  task automatic model(input bit m, output bit p, output logic [7:0] ea, output logic [7:0] ed);
    int cnt [256];
    bit bad;
    p = 1'b1; ea = 8'd0; ed = 8'd0;
    for (int i = 0; i < 256; i++) cnt[i] = 0;
    for (int i = 0; i < 256; i++) begin
      bad = m ? (cnt[mem[i]] > 0) : (int'(mem[i]) != i);
      cnt[mem[i]]++;
      if (bad && p) begin
        p = 1'b0; ea = 8'(i); ed = mem[i];
      end
    end
  endtask

  task automatic fill_identity();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
  endtask

  task automatic fill_reverse();
    for (int i = 0; i < 256; i++) mem[i] = 8'(255 - i);
  endtask

  // Run one sweep on the latency-1 instance, watching the read stream.
  task automatic sweep1(input bit m, output int busy, output int nreads, output bit seq_ok);
    en1 = 1'b1; mode1 = m;
    @(negedge clk);
    en1 = 1'b0;
    busy = 0; nreads = 0; seq_ok = 1'b1;
    while (!rdy1 && busy < 2000) begin
      if (rden1) begin
        if (addr1 != 8'(nreads)) seq_ok = 1'b0;
        nreads++;
      end
      busy++;
      @(negedge clk);
    end
    checks++;
    if (busy >= 2000) begin
      errors++; $display("FAIL sweep_timeout: busy=%0d required < 2000", busy);
    end
  endtask

  task automatic test_reset();
    checks += 6;
    if (rdy1 !== 1'b1)  begin errors++; $display("FAIL reset_rdy: got %b want 1", rdy1); end
    if (rden1 !== 1'b0) begin errors++; $display("FAIL reset_rden: got %b want 0", rden1); end
    if (addr1 !== 8'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr1); end
    if (pass1 !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b want 0", pass1); end
    if (ea1 !== 8'd0)   begin errors++; $display("FAIL reset_err_addr: got %0d want 0", ea1); end
    if (ed1 !== 8'd0)   begin errors++; $display("FAIL reset_err_data: got %0d want 0", ed1); end
  endtask

  task automatic test_identity();
    int busy, nreads; bit ok;
    fill_identity();
    sweep1(1'b0, busy, nreads, ok);
    checks += 6;
    if (pass1 !== 1'b1) begin errors++; $display("FAIL id_pass: got %b want 1", pass1); end
    if (ea1 !== 8'd0)   begin errors++; $display("FAIL id_err_addr: got %0d want 0", ea1); end
    if (ed1 !== 8'd0)   begin errors++; $display("FAIL id_err_data: got %0d want 0", ed1); end
    if (busy != 257)    begin errors++; $display("FAIL id_busy: got %0d want 257", busy); end
    if (nreads != 256)  begin errors++; $display("FAIL id_reads: got %0d want 256", nreads); end
    if (!ok)            begin errors++; $display("FAIL id_addr_seq: got out-of-order want 0..255"); end
  endtask

  task automatic test_identity_errors();
    int busy, nreads; bit ok;
    fill_identity();
    mem[17] = 8'd18; mem[40] = 8'd0;
    sweep1(1'b0, busy, nreads, ok);
    checks += 3;
    if (pass1 !== 1'b0)  begin errors++; $display("FAIL iderr_pass: got %b want 0", pass1); end
    if (ea1 !== 8'd17)   begin errors++; $display("FAIL iderr_err_addr: got %0d want 17", ea1); end
    if (ed1 !== 8'd18)   begin errors++; $display("FAIL iderr_err_data: got %0d want 18", ed1); end
  endtask

  task automatic test_permutation();
    int busy, nreads; bit ok;
    fill_reverse();
    sweep1(1'b1, busy, nreads, ok);
    checks += 3;
    if (pass1 !== 1'b1) begin errors++; $display("FAIL perm_pass: got %b want 1", pass1); end
    if (ea1 !== 8'd0)   begin errors++; $display("FAIL perm_err_addr: got %0d want 0", ea1); end
    if (ed1 !== 8'd0)   begin errors++; $display("FAIL perm_err_data: got %0d want 0", ed1); end
    sweep1(1'b0, busy, nreads, ok);
    checks += 3;
    if (pass1 !== 1'b0)  begin errors++; $display("FAIL rev_id_pass: got %b want 0", pass1); end
    if (ea1 !== 8'd0)    begin errors++; $display("FAIL rev_id_err_addr: got %0d want 0", ea1); end
    if (ed1 !== 8'd255)  begin errors++; $display("FAIL rev_id_err_data: got %0d want 255", ed1); end
  endtask

  task automatic test_duplicate();
    int busy, nreads; bit ok;
    fill_reverse();
    mem[200] = 8'd5;
    sweep1(1'b1, busy, nreads, ok);
    checks += 3;
    if (pass1 !== 1'b0)  begin errors++; $display("FAIL dup_pass: got %b want 0", pass1); end
    if (ea1 !== 8'd250)  begin errors++; $display("FAIL dup_err_addr: got %0d want 250", ea1); end
    if (ed1 !== 8'd5)    begin errors++; $display("FAIL dup_err_data: got %0d want 5", ed1); end
  endtask

  task automatic test_random();
    int busy, nreads, j, ncor; bit ok, m, ep; logic [7:0] eea, eed, t;
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(1, 0) == 1) begin
        fill_identity();
        for (int i = 255; i > 0; i--) begin
          j = $urandom_range(i, 0);
          t = mem[i]; mem[i] = mem[j]; mem[j] = t;
        end
      end else fill_identity();
      ncor = $urandom_range(3, 0);
      for (int c = 0; c < ncor; c++) mem[$urandom_range(255, 0)] = 8'($urandom_range(255, 0));
      m = 1'($urandom_range(1, 0));
      model(m, ep, eea, eed);
      sweep1(m, busy, nreads, ok);
      checks += 4;
      if (pass1 !== ep) begin errors++; $display("FAIL rnd%0d_pass: got %b want %b", it, pass1, ep); end
      if (ea1 !== eea)  begin errors++; $display("FAIL rnd%0d_err_addr: got %0d want %0d", it, ea1, eea); end
      if (ed1 !== eed)  begin errors++; $display("FAIL rnd%0d_err_data: got %0d want %0d", it, ed1, eed); end
      if (nreads != 256 || !ok) begin
        errors++; $display("FAIL rnd%0d_reads: got %0d reads seq_ok=%b want 256/1", it, nreads, ok);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, busy, nreads; bit ok;
    fill_identity();
    en1 = 1'b1; mode1 = 1'b0;
    @(negedge clk);
    en1 = 1'b0;
    n = 0;
    while (addr1 != 8'd100 && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (addr1 !== 8'd100) begin errors++; $display("FAIL mid_reach_addr: got %0d want 100", addr1); end
    rst_n = 1'b0;
    @(negedge clk);
    checks += 3;
    if (rdy1 !== 1'b1)  begin errors++; $display("FAIL mid_rdy: got %b want 1", rdy1); end
    if (rden1 !== 1'b0) begin errors++; $display("FAIL mid_rden: got %b want 0", rden1); end
    if (pass1 !== 1'b0) begin errors++; $display("FAIL mid_pass: got %b want 0", pass1); end
    rst_n = 1'b1;
    @(negedge clk);
    sweep1(1'b0, busy, nreads, ok);
    checks += 2;
    if (pass1 !== 1'b1) begin errors++; $display("FAIL mid_resweep_pass: got %b want 1", pass1); end
    if (nreads != 256)  begin errors++; $display("FAIL mid_resweep_reads: got %0d want 256", nreads); end
  endtask

  task automatic test_back_to_back();
    int busy, n;
    fill_identity();
    en3 = 1'b1; mode3 = 1'b0;
    n = 0;
    @(negedge clk);
    while (rdy3 && n < 10) begin @(negedge clk); n++; end
    for (int s = 0; s < 3; s++) begin
      busy = 0;
      while (!rdy3 && busy < 2000) begin busy++; @(negedge clk); end
      checks += 2;
      if (busy != 259)    begin errors++; $display("FAIL b2b%0d_busy: got %0d want 259", s, busy); end
      if (pass3 !== 1'b1) begin errors++; $display("FAIL b2b%0d_pass: got %b want 1", s, pass3); end
      if (s == 2) en3 = 1'b0;
      @(negedge clk);
      if (s < 2) begin
        checks++;
        if (rdy3 !== 1'b0) begin errors++; $display("FAIL b2b%0d_rdy_gap: got %b want 0", s, rdy3); end
      end
    end
    checks++;
    if (rdy3 !== 1'b1) begin errors++; $display("FAIL b2b_stop_rdy: got %b want 1", rdy3); end
  endtask

  initial begin
    rst_n = 1'b0; en1 = 1'b0; mode1 = 1'b0; en3 = 1'b0; mode3 = 1'b0;
    fill_identity();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    @(negedge clk);
    test_identity();
    test_identity_errors();
    test_permutation();
    test_duplicate();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
